// File: rtl/bus_load_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_load_sequencer_if
// Description : Request and bus bundle for bus_load_sequencer.
//               master modport : upstream requester / bank-side observer
//               slave  modport : the sequencer itself
//               Signals: In_Valid/In_Ready/In_Sel/In_Data (request channel),
//               Data_Bus, A_EN/B_EN/C_EN (load side), Busy, Err, Count.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_load_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int c_COUNT_W = $clog2(DEPTH) + 1;

  logic                 In_Valid;
  logic                 In_Ready;
  logic [1:0]           In_Sel;
  logic [7:0]           In_Data;
  logic [7:0]           Data_Bus;
  logic                 A_EN;
  logic                 B_EN;
  logic                 C_EN;
  logic                 Busy;
  logic                 Err;
  logic [c_COUNT_W-1:0] Count;

  modport master (
    output In_Valid, In_Sel, In_Data,
    input  In_Ready, Data_Bus, A_EN, B_EN, C_EN, Busy, Err, Count
  );

  modport slave (
    input  In_Valid, In_Sel, In_Data,
    output In_Ready, Data_Bus, A_EN, B_EN, C_EN, Busy, Err, Count
  );
endinterface
`default_nettype wire

// File: rtl/bus_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bus_load_sequencer
// Description : Buffers (target, data) write requests in a DEPTH-entry FIFO
//               and replays each one onto the shared 8-bit Data_Bus with a
//               single one-cycle load enable (A_EN/B_EN/C_EN). GAP idle cycles
//               may be inserted after every load pulse.
// Ports       : Clock  - rising-edge clock
//               Reset  - asynchronous active-high reset
//               bus    - bus_load_sequencer_if.slave (request channel,
//                        Data_Bus, enables, Busy, Err, Count)
// Config      : BUS_SEQ_BCAST_EN - when defined, In_Sel=3 broadcasts to all
//               three registers; otherwise it is handshaken, dropped and
//               flagged on Err.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_load_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  wire logic             Clock,
  input  wire logic             Reset,
  bus_load_sequencer_if.slave   bus
);

  localparam int               c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               c_CW       = $clog2(DEPTH) + 1;
  localparam logic [c_CW-1:0]  c_FULL     = c_CW'(DEPTH);
  localparam bit               c_NO_GAP   = (GAP == 0);
  // Counter preload on entering SETTLE; SETTLE then lasts exactly GAP cycles.
  localparam logic [3:0]       c_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // FIFO storage: {sel[1:0], data[7:0]}
  logic [9:0]       r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_gap_cnt;
  logic [3:0]       w_gap_cnt_nxt;
  logic [7:0]       r_bus;
  logic [7:0]       w_bus_nxt;
  logic [2:0]       r_en;        // {C, B, A}
  logic [2:0]       w_en_nxt;
  logic             r_err;

  logic             w_ready;
  logic             w_accept;
  logic             w_reject;
  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  logic [9:0]       w_head;

  function automatic logic [2:0] f_sel_to_en(input logic [1:0] sel);
    logic [2:0] en;
    case (sel)
      2'd0:    en = 3'b001;
      2'd1:    en = 3'b010;
      2'd2:    en = 3'b100;
`ifdef BUS_SEQ_BCAST_EN
      default: en = 3'b111;
`else
      default: en = 3'b000;  // never queued in this build
`endif
    endcase
    return en;
  endfunction

  // Ready depends only on the registered count, so a pop in the same cycle
  // does not reopen a full FIFO until the following cycle.
  assign w_ready     = (r_count != c_FULL);
  assign w_accept    = bus.In_Valid && w_ready;
  assign w_not_empty = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

`ifdef BUS_SEQ_BCAST_EN
  assign w_reject = 1'b0;
`else
  // Broadcast requests complete the handshake but are dropped.
  assign w_reject = w_accept && (bus.In_Sel == 2'd3);
`endif

  assign w_push = w_accept && !w_reject;

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.In_Sel, bus.In_Data};
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 4'd0;
      r_bus     <= 8'h00;
      r_en      <= 3'b000;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_bus     <= w_bus_nxt;
      r_en      <= w_en_nxt;
      r_err     <= w_reject;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM: next state and registered-output inputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_cnt_nxt = r_gap_cnt;
    w_bus_nxt     = r_bus;
    w_en_nxt      = 3'b000;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_bus_nxt   = w_head[7:0];
          w_en_nxt    = f_sel_to_en(w_head[9:8]);
          w_state_nxt = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (c_NO_GAP && w_not_empty) begin
          // Back-to-back transfer, one per cycle.
          w_pop       = 1'b1;
          w_bus_nxt   = w_head[7:0];
          w_en_nxt    = f_sel_to_en(w_head[9:8]);
          w_state_nxt = ST_LOAD;
        end else if (!c_NO_GAP) begin
          w_gap_cnt_nxt = c_GAP_LOAD;
          w_state_nxt   = ST_SETTLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.In_Ready = w_ready;
  assign bus.Data_Bus = r_bus;
  assign bus.A_EN     = r_en[0];
  assign bus.B_EN     = r_en[1];
  assign bus.C_EN     = r_en[2];
  assign bus.Busy     = w_not_empty || (r_state != ST_IDLE);
  assign bus.Err      = r_err;
  assign bus.Count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_load_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bus_load_sequencer
// Description : Self-checking bench for bus_load_sequencer. Two instances
//               (GAP=0 and GAP=2, DEPTH=4) share one request stream; each is
//               compared every cycle against a transaction-level model, with
//               a directed vector table and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_load_sequencer;

  localparam int c_DEPTH = 4;
`ifdef BUS_SEQ_BCAST_EN
  localparam bit c_BCAST = 1'b1;
`else
  localparam bit c_BCAST = 1'b0;
`endif

  logic       Clock;
  logic       Reset;
  bit         clk_run;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;

  int n_checks;
  int n_fail;
  int cyc;

  bus_load_sequencer_if #(.DEPTH(c_DEPTH)) bif0 ();
  bus_load_sequencer_if #(.DEPTH(c_DEPTH)) bif2 ();

  assign bif0.In_Valid = in_valid;
  assign bif0.In_Sel   = in_sel;
  assign bif0.In_Data  = in_data;
  assign bif2.In_Valid = in_valid;
  assign bif2.In_Sel   = in_sel;
  assign bif2.In_Data  = in_data;

  bus_load_sequencer #(.DEPTH(c_DEPTH), .GAP(0)) dut0 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bif0)
  );

  bus_load_sequencer #(.DEPTH(c_DEPTH), .GAP(2)) dut2 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bif2)
  );

  initial Clock = 1'b0;
  always begin
    #5;
    if (clk_run) Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Transaction-level reference model (index 0: GAP=0, index 1: GAP=2)
  // --------------------------------------------------------------------------
  logic [9:0] m_q [2][16];
  int         m_head [2];
  int         m_tail [2];
  int         m_last [2];
  bit         m_have [2];
  logic [7:0] e_bus  [2];
  logic [2:0] e_en   [2];
  int         e_cnt  [2];
  bit         e_busy [2];
  bit         e_err  [2];

  function automatic int gap_of(input int g);
    return (g == 0) ? 0 : 2;
  endfunction

  task automatic m_reset();
    for (int g = 0; g < 2; g++) begin
      m_head[g] = 0; m_tail[g] = 0; m_last[g] = 0; m_have[g] = 1'b0;
      e_bus[g] = 8'h00; e_en[g] = 3'b000; e_cnt[g] = 0;
      e_busy[g] = 1'b0; e_err[g] = 1'b0;
    end
  endtask

  // One rising edge: an entry may leave once it was queued at an earlier
  // edge and the required spacing since the previous load pulse has elapsed.
  task automatic m_step(input int g, input bit v, input logic [1:0] s,
                        input logic [7:0] d);
    int  gap;
    int  cnt;
    bit  pop;
    bit  acc;
    bit  rej;
    logic [9:0] ent;
    gap = gap_of(g);
    cnt = m_tail[g] - m_head[g];
    pop = (cnt > 0) && (!m_have[g] ||
          cyc >= m_last[g] + ((gap == 0) ? 1 : gap + 2));
    acc = v && (cnt != c_DEPTH);
    rej = acc && (s == 2'd3) && !c_BCAST;
    e_en[g] = 3'b000;
    if (pop) begin
      ent       = m_q[g][m_head[g] % 16];
      m_head[g] = m_head[g] + 1;
      e_bus[g]  = ent[7:0];
      e_en[g]   = (ent[9:8] == 2'd3) ? 3'b111 : 3'(1 << ent[9:8]);
      m_last[g] = cyc;
      m_have[g] = 1'b1;
    end
    if (acc && !rej) begin
      m_q[g][m_tail[g] % 16] = {s, d};
      m_tail[g] = m_tail[g] + 1;
    end
    e_err[g]  = rej;
    e_cnt[g]  = m_tail[g] - m_head[g];
    e_busy[g] = (e_cnt[g] != 0) || (m_have[g] && cyc <= m_last[g] + gap);
  endtask

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] bus_v;
    logic [2:0] en_v;
    logic [2:0] cnt_v;
    logic       rdy_v, busy_v, err_v;
    for (int g = 0; g < 2; g++) begin
      if (g == 0) begin
        bus_v = bif0.Data_Bus; en_v = {bif0.C_EN, bif0.B_EN, bif0.A_EN};
        cnt_v = bif0.Count; rdy_v = bif0.In_Ready; busy_v = bif0.Busy;
        err_v = bif0.Err;
      end else begin
        bus_v = bif2.Data_Bus; en_v = {bif2.C_EN, bif2.B_EN, bif2.A_EN};
        cnt_v = bif2.Count; rdy_v = bif2.In_Ready; busy_v = bif2.Busy;
        err_v = bif2.Err;
      end
      chk($sformatf("%s.g%0d.data_bus", tag, g), 32'(bus_v),  32'(e_bus[g]));
      chk($sformatf("%s.g%0d.enables",  tag, g), 32'(en_v),   32'(e_en[g]));
      chk($sformatf("%s.g%0d.count",    tag, g), 32'(cnt_v),  32'(e_cnt[g]));
      chk($sformatf("%s.g%0d.in_ready", tag, g), 32'(rdy_v),
          32'(e_cnt[g] != c_DEPTH));
      chk($sformatf("%s.g%0d.busy",     tag, g), 32'(busy_v), 32'(e_busy[g]));
      chk($sformatf("%s.g%0d.err",      tag, g), 32'(err_v),  32'(e_err[g]));
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [1:0] s,
                      input logic [7:0] d);
    in_valid = v; in_sel = s; in_data = d;
    @(posedge Clock);
    cyc++;
    m_step(0, v, s, d);
    m_step(1, v, s, d);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    clk_run = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    m_reset();
    compare_all(tag);
    #2;
    Reset = 1'b0;
    #3;
    clk_run = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors for the GAP=0 instance
  // --------------------------------------------------------------------------
  typedef struct {
    bit         v;
    logic [1:0] s;
    logic [7:0] d;
    logic [2:0] en;    // {C,B,A} after the edge
    logic [7:0] bus;
    int         cnt;
    bit         busy;
    bit         err;
  } vec_t;

  vec_t tv [11];

  initial begin
    int         pt [6];
    logic [7:0] pd [6];
    int         np;
    int         k;
    int         stray;
    bit         rdy;

    n_checks = 0; n_fail = 0; cyc = 0;
    clk_run = 1'b0; Reset = 1'b0;
    in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
    m_reset();

    // Single write to B, then back-to-back A/B/C, then broadcast.
    tv[0]  = '{1'b1, 2'd1, 8'h5A, 3'b000, 8'h00, 1, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 2'd0, 8'h00, 3'b010, 8'h5A, 0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 2'd0, 8'h00, 3'b000, 8'h5A, 0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 2'd0, 8'h11, 3'b000, 8'h5A, 1, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 2'd1, 8'h22, 3'b001, 8'h11, 1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 2'd2, 8'h33, 3'b010, 8'h22, 1, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 2'd0, 8'h00, 3'b100, 8'h33, 0, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 2'd0, 8'h00, 3'b000, 8'h33, 0, 1'b0, 1'b0};
`ifdef BUS_SEQ_BCAST_EN
    tv[8]  = '{1'b1, 2'd3, 8'hC3, 3'b000, 8'h33, 1, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 2'd0, 8'h00, 3'b111, 8'hC3, 0, 1'b1, 1'b0};
    tv[10] = '{1'b0, 2'd0, 8'h00, 3'b000, 8'hC3, 0, 1'b0, 1'b0};
`else
    tv[8]  = '{1'b1, 2'd3, 8'hC3, 3'b000, 8'h33, 0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 2'd0, 8'h00, 3'b000, 8'h33, 0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 2'd0, 8'h00, 3'b000, 8'h33, 0, 1'b0, 1'b0};
`endif

    // Reset while the clock is stopped.
    #3;
    Reset = 1'b1;
    #1;
    m_reset();
    compare_all("reset");
    #3;
    Reset = 1'b0;
    #3;
    clk_run = 1'b1;

    // Table-driven sequence.
    for (int i = 0; i < 11; i++) begin
      step("table", tv[i].v, tv[i].s, tv[i].d);
      chk($sformatf("vec%0d.enables", i),
          32'({bif0.C_EN, bif0.B_EN, bif0.A_EN}), 32'(tv[i].en));
      chk($sformatf("vec%0d.data_bus", i), 32'(bif0.Data_Bus), 32'(tv[i].bus));
      chk($sformatf("vec%0d.count", i), 32'(bif0.Count), 32'(tv[i].cnt));
      chk($sformatf("vec%0d.busy", i), 32'(bif0.Busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d.err", i), 32'(bif0.Err), 32'(tv[i].err));
    end
    for (int i = 0; i < 12; i++) step("drain", 1'b0, 2'd0, 8'h00);

    // GAP=2 with In_Valid held: fill to full, spaced pulses, order kept.
    np = 0; k = 0;
    for (int c = 0; c < 30; c++) begin
      rdy = (m_tail[1] - m_head[1]) != c_DEPTH;
      step("gapfull", (k < 6), 2'(k % 3), 8'hA0 + 8'(k));
      if ((k < 6) && rdy) k++;
      if (c == 4) chk("gapfull.ready_low_when_full", 32'(bif2.In_Ready), 32'd0);
      if (c == 5) chk("gapfull.ready_after_pop", 32'(bif2.In_Ready), 32'd1);
      if ({bif2.C_EN, bif2.B_EN, bif2.A_EN} != 3'b000 && np < 6) begin
        pt[np] = c; pd[np] = bif2.Data_Bus; np++;
      end
    end
    in_valid = 1'b0;
    chk("gapfull.pulse_count", 32'(np), 32'd6);
    for (int i = 0; i < np; i++) begin
      chk($sformatf("gapfull.order%0d", i), 32'(pd[i]), 32'(8'hA0 + 8'(i)));
      if (i > 0)
        chk($sformatf("gapfull.spacing%0d", i), 32'(pt[i] - pt[i-1]), 32'd4);
    end
    for (int i = 0; i < 10; i++) step("drain", 1'b0, 2'd0, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", (($urandom % 4) != 0), 2'($urandom % 4), 8'($urandom));
    end
    for (int i = 0; i < 30; i++) step("drain", 1'b0, 2'd0, 8'h00);

    // Reset while B_EN is high on the GAP=2 instance with 3 entries queued.
    step("midrst", 1'b1, 2'd0, 8'h01);
    step("midrst", 1'b1, 2'd1, 8'hBB);
    step("midrst", 1'b1, 2'd2, 8'h02);
    step("midrst", 1'b1, 2'd0, 8'h03);
    step("midrst", 1'b1, 2'd2, 8'h04);
    step("midrst", 1'b0, 2'd0, 8'h00);
    chk("midrst.b_en_before", 32'(bif2.B_EN), 32'd1);
    chk("midrst.count_before", 32'(bif2.Count), 32'd3);
    async_reset("midrst.async");
    chk("midrst.b_en_dropped", 32'(bif2.B_EN), 32'd0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step("postrst", 1'b0, 2'd0, 8'h00);
      if ({bif2.C_EN, bif2.B_EN, bif2.A_EN, bif0.C_EN, bif0.B_EN, bif0.A_EN}
          != 6'd0) stray++;
    end
    chk("postrst.no_replay", 32'(stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
